soft_error_monitor: RTL and testbench
=====================================

SOFT_ERROR_MONITOR -- requirements
Module: soft_error_monitor

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: checked word width; must be divisible by LANES.
REQ-002 SHALL have parameter LANES, default 4: number of parity lanes; lane width W = DATA_SIZE/LANES.
REQ-003 SHALL have parameter ODD_PARITY, default 0: 0 = even parity, 1 = odd parity.
REQ-004 SHALL have parameter CNT_WIDTH, default 8: error counter width.
REQ-005 SHALL have parameter THRESHOLD, default 4: error count that raises alarm; range 1..2^CNT_WIDTH-1.
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1: data and parity_bits are valid this cycle.
REQ-009 SHALL have port data, input, DATA_SIZE: word under check.
REQ-010 SHALL have port parity_bits, input, LANES: received parity bit per lane.
REQ-011 SHALL have port clear, input, 1: synchronous clear of accumulated status.
REQ-012 SHALL have port out_valid, output, 1: check result valid.
REQ-013 SHALL have port error_flag, output, 1: any lane of the checked word mismatched.
REQ-014 SHALL have port lane_error, output, LANES: per-lane mismatch of the checked word.
REQ-015 SHALL have port sticky_error, output, LANES: OR of all lane_error since last clear/reset.
REQ-016 SHALL have port error_count, output, CNT_WIDTH: count of erroneous words.
REQ-017 SHALL have port alarm, output, 1: threshold reached.
REQ-018 SHALL have port first_lane, output, max(1,$clog2(LANES)): lowest erring lane of the first erroneous word since clear.
REQ-019 SHALL have port first_valid, output, 1: first_lane holds a captured value.

Function
REQ-020 Lane i SHALL cover data[i*W+W-1 : i*W]; mismatch_i = (^slice) XOR ODD_PARITY XOR parity_bits[i].
REQ-021 Latency SHALL be one cycle: a word accepted at edge N drives out_valid, error_flag and lane_error after edge N+1.
REQ-022 When in_valid=0, the next cycle SHALL have out_valid=0, error_flag=0, lane_error=0.
REQ-023 error_flag SHALL equal OR of lane_error.
REQ-024 error_count SHALL increment by exactly 1 per erroneous word, regardless of lane count, and saturate at 2^CNT_WIDTH-1.
REQ-025 sticky_error, error_count, alarm and first_lane SHALL update on the same edge as error_flag.
REQ-026 Status FSM SHALL have states CLEAN (no errors), ERRORED (0 < count < THRESHOLD) and ALARM (count >= THRESHOLD); alarm=1 only in ALARM.
REQ-027 Transitions: CLEAN->ERRORED on an erroneous word (CLEAN->ALARM directly if THRESHOLD=1); ERRORED->ALARM when the updated count reaches THRESHOLD; any state->CLEAN on clear; ALARM SHALL be held until clear.
REQ-028 first_lane/first_valid SHALL be captured only on the transition out of CLEAN; later errors SHALL NOT overwrite them.
REQ-029 clear coincident with an erroneous word: clear SHALL win for sticky_error, error_count, alarm and first_valid (all zero); error_flag/lane_error SHALL still report the word.
REQ-030 Back-to-back in_valid SHALL be accepted every cycle with no stalls.

Reset
REQ-031 reset_n low SHALL asynchronously force all outputs to 0 and the FSM to CLEAN; release SHALL be synchronous to clk.
REQ-032 Reset asserted mid-stream SHALL discard the in-flight word; no output SHALL be valid in the first cycle after release.

Structure
REQ-033 FSM state encoding and the ODD_PARITY mode constants SHALL live in shared package soft_error_pkg.
REQ-034 Per-lane parity compare SHALL be sub-module parity_lane_check (parameter W), instantiated LANES times via generate.

Verification
REQ-035 Defaults, data=32'h0000_0001, parity_bits=4'b0001, in_valid=1 -> next cycle out_valid=1, error_flag=0, count=0.
REQ-036 data=32'h0101_0000, parity_bits=4'b0000 -> lane_error=4'b1100, error_flag=1, count=1, first_lane=2, sticky=4'b1100.
REQ-037 Four erroneous words back-to-back -> alarm=1 on the fourth result edge; a fifth error -> count=5, first_lane unchanged.
REQ-038 CNT_WIDTH=2, 5 erroneous words -> count saturates at 3.
REQ-039 clear with erroneous word in same cycle -> next cycle error_flag=1, count=0, sticky=0, alarm=0, first_valid=0.
REQ-040 reset_n low mid-stream -> outputs 0 immediately, without waiting for a clock edge; first post-release cycle out_valid=0.

Source files
------------

// File: rtl/soft_error_pkg.sv
// Shared definitions for the soft-error monitor: status FSM encoding and
// the parity-mode constants used by the per-lane checkers.
package soft_error_pkg;

   typedef enum logic [1:0] {
      ST_CLEAN   = 2'd0,
      ST_ERRORED = 2'd1,
      ST_ALARM   = 2'd2
   } state_e;

   localparam int PARITY_EVEN = 0;
   localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/parity_lane_check.sv
// Single-lane parity compare: flags a mismatch between the recomputed parity
// of one data slice and the parity bit that travelled with it.
module parity_lane_check
   import soft_error_pkg::*;
#(
   parameter int W          = 8,
   parameter int ODD_PARITY = PARITY_EVEN
) (
   input  logic [W-1:0] slice_i,
   input  logic         parity_i,
   output logic         mismatch_o
);

   localparam logic ODD_BIT = (ODD_PARITY == PARITY_ODD);

   assign mismatch_o = (^slice_i) ^ ODD_BIT ^ parity_i;

endmodule

// File: rtl/soft_error_monitor.sv
// Parity-based soft-error monitor: one-cycle per-word lane check plus
// accumulated status (sticky lanes, saturating count, alarm FSM, first lane).
module soft_error_monitor
   import soft_error_pkg::*;
#(
   parameter int DATA_SIZE  = 32,
   parameter int LANES      = 4,
   parameter int ODD_PARITY = PARITY_EVEN,
   parameter int CNT_WIDTH  = 8,
   parameter int THRESHOLD  = 4,
   localparam int FL_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic [DATA_SIZE-1:0] data,
   input  logic [LANES-1:0]     parity_bits,
   input  logic                 clear,
   output logic                 out_valid,
   output logic                 error_flag,
   output logic [LANES-1:0]     lane_error,
   output logic [LANES-1:0]     sticky_error,
   output logic [CNT_WIDTH-1:0] error_count,
   output logic                 alarm,
   output logic [FL_W-1:0]      first_lane,
   output logic                 first_valid
);

   localparam int                   W       = DATA_SIZE / LANES;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] THRESH  = CNT_WIDTH'(THRESHOLD);

   logic [LANES-1:0]     lane_mm;
   logic [LANES-1:0]     lane_error_d, lane_error_q;
   logic [LANES-1:0]     sticky_d, sticky_q;
   logic [CNT_WIDTH-1:0] count_d, count_q;
   logic [FL_W-1:0]      first_lane_d, first_lane_q;
   logic                 first_valid_d, first_valid_q;
   logic                 out_valid_q;
   logic                 word_err;
   logic [FL_W-1:0]      lowest_lane;
   state_e               state_d, state_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      parity_lane_check #(
         .W          (W),
         .ODD_PARITY (ODD_PARITY)
      ) u_lane (
         .slice_i    (data[i*W +: W]),
         .parity_i   (parity_bits[i]),
         .mismatch_o (lane_mm[i])
      );
   end

   always_comb begin
      lane_error_d  = in_valid ? lane_mm : '0;
      word_err      = |lane_error_d;
      lowest_lane   = '0;
      sticky_d      = sticky_q;
      count_d       = count_q;
      first_lane_d  = first_lane_q;
      first_valid_d = first_valid_q;
      state_d       = state_q;

      // Scan high-to-low so the lowest erring lane is the one left standing.
      for (int i = LANES - 1; i >= 0; i--) begin
         if (lane_mm[i]) lowest_lane = FL_W'(i);
      end

      if (clear) begin
         sticky_d      = '0;
         count_d       = '0;
         first_lane_d  = '0;
         first_valid_d = 1'b0;
         state_d       = ST_CLEAN;
      end else if (word_err) begin
         sticky_d = sticky_q | lane_error_d;
         if (count_q != CNT_MAX) count_d = count_q + 1'b1;
         case (state_q)
            ST_CLEAN: begin
               first_lane_d  = lowest_lane;
               first_valid_d = 1'b1;
               state_d       = (count_d >= THRESH) ? ST_ALARM : ST_ERRORED;
            end
            ST_ERRORED: if (count_d >= THRESH) state_d = ST_ALARM;
            ST_ALARM:   state_d = ST_ALARM;
            default:    state_d = ST_CLEAN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q   <= 1'b0;
         lane_error_q  <= '0;
         sticky_q      <= '0;
         count_q       <= '0;
         first_lane_q  <= '0;
         first_valid_q <= 1'b0;
         state_q       <= ST_CLEAN;
      end else begin
         out_valid_q   <= in_valid;
         lane_error_q  <= lane_error_d;
         sticky_q      <= sticky_d;
         count_q       <= count_d;
         first_lane_q  <= first_lane_d;
         first_valid_q <= first_valid_d;
         state_q       <= state_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign lane_error   = lane_error_q;
   assign error_flag   = |lane_error_q;
   assign sticky_error = sticky_q;
   assign error_count  = count_q;
   assign alarm        = (state_q == ST_ALARM);
   assign first_lane   = first_lane_q;
   assign first_valid  = first_valid_q;

endmodule

// File: tb/tb_soft_error_monitor.sv
// Bench for soft_error_monitor: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_soft_error_monitor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] data;
   logic [3:0]  parity_bits;
   logic        clear;

   logic       out_valid,  error_flag,  alarm,  first_valid;
   logic [3:0] lane_error, sticky_error;
   logic [7:0] error_count;
   logic [1:0] first_lane;

   logic       out_valid2, error_flag2, alarm2, first_valid2;
   logic [3:0] lane_error2, sticky_error2;
   logic [1:0] error_count2;
   logic [1:0] first_lane2;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic       m_ov;
   logic [3:0] m_le, m_sticky;
   int         m_cnt, m_cnt2, m_fl;
   logic       m_fv;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic [3:0]  p;
      logic        c;
      logic [3:0]  le;
      logic [3:0]  sticky;
      logic [7:0]  cnt;
      logic        alarm;
      logic [1:0]  fl;
      logic        fv;
   } vec_t;

   always #5 clk = ~clk;

   soft_error_monitor dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .data(data),
      .parity_bits(parity_bits), .clear(clear), .out_valid(out_valid),
      .error_flag(error_flag), .lane_error(lane_error), .sticky_error(sticky_error),
      .error_count(error_count), .alarm(alarm), .first_lane(first_lane),
      .first_valid(first_valid)
   );

   soft_error_monitor #(.CNT_WIDTH(2), .THRESHOLD(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .data(data),
      .parity_bits(parity_bits), .clear(clear), .out_valid(out_valid2),
      .error_flag(error_flag2), .lane_error(lane_error2), .sticky_error(sticky_error2),
      .error_count(error_count2), .alarm(alarm2), .first_lane(first_lane2),
      .first_valid(first_valid2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ov = 0; m_le = 0; m_sticky = 0; m_cnt = 0; m_cnt2 = 0; m_fl = 0; m_fv = 0;
   endtask

   // Behavioural reference: even parity means a lane's ones-count plus its
   // parity bit must be even.
   task automatic model_step(input logic v, input logic [31:0] d, input logic [3:0] p,
                             input logic c);
      logic [3:0] e;
      for (int i = 0; i < 4; i++)
         e[i] = v && ((($countones(d[i*8 +: 8]) + int'(p[i])) % 2) != 0);
      m_ov = v;
      m_le = e;
      if (c) begin
         m_sticky = 0; m_cnt = 0; m_cnt2 = 0; m_fl = 0; m_fv = 0;
      end else if (e != 0) begin
         if (!m_fv) begin
            m_fv = 1;
            for (int i = 3; i >= 0; i--) if (e[i]) m_fl = i;
         end
         m_sticky = m_sticky | e;
         m_cnt  = (m_cnt  + 1 > 255) ? 255 : m_cnt + 1;
         m_cnt2 = (m_cnt2 + 1 > 3)   ? 3   : m_cnt2 + 1;
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] p,
                        input logic c);
      in_valid = v; data = d; parity_bits = p; clear = c;
      model_step(v, d, p, c);
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".out_valid"},  32'(out_valid),    32'(m_ov));
      chk({tag, ".error_flag"}, 32'(error_flag),   32'(|m_le));
      chk({tag, ".lane_error"}, 32'(lane_error),   32'(m_le));
      chk({tag, ".sticky"},     32'(sticky_error), 32'(m_sticky));
      chk({tag, ".count"},      32'(error_count),  32'(m_cnt));
      chk({tag, ".alarm"},      32'(alarm),        32'(m_cnt >= 4));
      chk({tag, ".first_valid"},32'(first_valid),  32'(m_fv));
      chk({tag, ".first_lane"}, 32'(first_lane),   32'(m_fl));
      chk({tag, ".count2"},     32'(error_count2), 32'(m_cnt2));
      chk({tag, ".alarm2"},     32'(alarm2),       32'(m_cnt2 >= 2));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".outs"}, {22'd0, out_valid, error_flag, lane_error, sticky_error,
                           first_valid, first_lane, alarm}, 32'd0);
      chk({tag, ".count"}, 32'(error_count), 32'd0);
      chk({tag, ".outs2"}, {20'd0, out_valid2, error_flag2, lane_error2,
                            sticky_error2, alarm2, error_count2, first_valid2}, 32'd0);
   endtask

   initial begin
      vec_t tbl[9];
      logic [31:0] rd;
      logic [3:0]  rp, flips;

      //        v  data          par     clr  le       sticky   cnt  alm  fl fv
      tbl[0] = '{1, 32'h0000_0001, 4'b0001, 0, 4'b0000, 4'b0000, 8'd0, 0, 2'd0, 0};
      tbl[1] = '{1, 32'h0101_0000, 4'b0000, 0, 4'b1100, 4'b1100, 8'd1, 0, 2'd2, 1};
      tbl[2] = '{0, 32'h0101_0000, 4'b0000, 0, 4'b0000, 4'b1100, 8'd1, 0, 2'd2, 1};
      tbl[3] = '{1, 32'h0000_00FF, 4'b0001, 0, 4'b0001, 4'b1101, 8'd2, 0, 2'd2, 1};
      tbl[4] = '{1, 32'h0000_0000, 4'b1000, 0, 4'b1000, 4'b1101, 8'd3, 0, 2'd2, 1};
      tbl[5] = '{1, 32'h0000_0000, 4'b0010, 0, 4'b0010, 4'b1111, 8'd4, 1, 2'd2, 1};
      tbl[6] = '{1, 32'h0000_0000, 4'b0100, 0, 4'b0100, 4'b1111, 8'd5, 1, 2'd2, 1};
      tbl[7] = '{1, 32'h0000_0000, 4'b1111, 1, 4'b1111, 4'b0000, 8'd0, 0, 2'd0, 0};
      tbl[8] = '{1, 32'h0000_0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd0, 0, 2'd0, 0};

      reset_n = 0; in_valid = 0; data = 0; parity_bits = 0; clear = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check_all_zero("reset");
      reset_n = 1;

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].c);
         chk($sformatf("tbl%0d.out_valid", i),  32'(out_valid),    32'(tbl[i].v));
         chk($sformatf("tbl%0d.error_flag", i), 32'(error_flag),   32'(|tbl[i].le));
         chk($sformatf("tbl%0d.lane_error", i), 32'(lane_error),   32'(tbl[i].le));
         chk($sformatf("tbl%0d.sticky", i),     32'(sticky_error), 32'(tbl[i].sticky));
         chk($sformatf("tbl%0d.count", i),      32'(error_count),  32'(tbl[i].cnt));
         chk($sformatf("tbl%0d.alarm", i),      32'(alarm),        32'(tbl[i].alarm));
         chk($sformatf("tbl%0d.first_lane", i), 32'(first_lane),   32'(tbl[i].fl));
         chk($sformatf("tbl%0d.first_valid", i),32'(first_valid),  32'(tbl[i].fv));
         chk($sformatf("tbl%0d.count2", i),     32'(error_count2), 32'(m_cnt2));
      end

      // Five back-to-back errors: alarm on the fourth, small counter saturates
      for (int k = 0; k < 5; k++) begin
         drive(1, 32'h0000_0000, (k == 0) ? 4'b0010 : 4'b0001, 0);
         check_model($sformatf("b2b%0d", k));
         if (k == 3) chk("b2b.alarm4", 32'(alarm), 32'd1);
      end
      chk("b2b.count5", 32'(error_count), 32'd5);
      chk("b2b.first_lane", 32'(first_lane), 32'd1);
      chk("b2b.sat2", 32'(error_count2), 32'd3);

      // Clear coincident with an erroneous word
      drive(1, 32'h0000_0000, 4'b0100, 1);
      chk("clr.error_flag", 32'(error_flag), 32'd1);
      chk("clr.status", {error_count, sticky_error, alarm, first_valid}, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rd = $urandom;
         flips = 0;
         for (int i = 0; i < 4; i++) flips[i] = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < 4; i++) rp[i] = ^rd[i*8 +: 8];
         drive($urandom_range(0, 3) != 0, rd, rp ^ flips, $urandom_range(0, 39) == 0);
         check_model($sformatf("rnd%0d", n));
      end

      // Reset mid-stream with an erroneous word in flight
      drive(1, 32'h0000_0000, 4'b1000, 0);
      check_model("pre_rst");
      #2 reset_n = 0;
      #1 check_all_zero("async_rst");
      model_reset();
      @(posedge clk); #1;
      in_valid = 1; data = 32'h0000_0001; parity_bits = 4'b0001; clear = 0;
      reset_n = 1;
      #2;
      chk("post_rel.out_valid", 32'(out_valid), 32'd0);
      model_step(1, 32'h0000_0001, 4'b0001, 0);
      @(posedge clk); #1;
      check_model("post_rel1");
      drive(0, 32'h0, 4'b0, 0);
      check_model("post_rel2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
